// File: rtl/ariane_pkg.sv
// Shared core types used across the Ariane front end.
//   scoreboard_entry_t : decoded instruction as handed from decode to issue
//   ariane_cfg_t       : core configuration record (IdQueueDepth sizes the
//                        ID/issue queue)
package ariane_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  op;
      logic [4:0]  rd;
   } scoreboard_entry_t;

   typedef struct packed {
      int unsigned IdQueueDepth;
   } ariane_cfg_t;

   localparam ariane_cfg_t ArianeDefaultConfig = '{IdQueueDepth: 32'd2};

endpackage

// File: rtl/id_issue_queue_pkg.sv
// Local types and helpers for the ID/issue queue.
//   id_entry_t : one storage slot, decoded entry plus its control-flow flag
//   ptr_width  : pointer width for a given depth (at least one bit)
package id_issue_queue_pkg;

   import ariane_pkg::*;

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic              is_ctrl_flow;
   } id_entry_t;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

endpackage

// File: rtl/id_issue_queue_sva.sv
// Property checker for the ID/issue queue occupancy and handshake.
// Ports: clock/reset, occupancy counters, ack and decode handshake signals.
module id_issue_queue_sva
   import ariane_pkg::*;
#(
   parameter int unsigned  Depth       = 2,
   parameter int unsigned  MaxCtrlFlow = Depth,
   parameter bit           FallThrough = 1'b0,
   localparam int unsigned CntW        = $clog2(Depth + 1)
) (
   input logic              clk_i,
   input logic              rst_ni,
   input logic [CntW-1:0]   count_i,
   input logic [CntW-1:0]   cf_count_i,
   input logic              issue_instr_ack_i,
   input logic              decode_valid_i,
   input logic              decode_ready_i,
   input scoreboard_entry_t decoded_entry_i
);

   a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_i <= CntW'(Depth));

   a_cf_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cf_count_i <= CntW'(MaxCtrlFlow));

   a_cf_le_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cf_count_i <= count_i);

   a_ack_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      FallThrough || !issue_instr_ack_i || (count_i != {CntW{1'b0}}));

   a_stable_in: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (decode_valid_i && !decode_ready_i) |=> (!decode_valid_i || $stable(decoded_entry_i)))
      else $warning("decoded entry changed while stalled");

endmodule

// File: rtl/id_queue_ctrl.sv
// Control path of the ID/issue queue: read/write pointers, occupancy and
// control-flow occupancy, plus the ready/pop handshake decisions.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop every buffered entry
//   decode_valid_i       decoder offers an entry
//   is_ctrl_flow_i       offered entry is control flow
//   issue_instr_ack_i    issue stage consumes the head
//   head_ctrl_flow_i     control-flow flag of the entry currently at the head
//   decode_ready_o       offered entry is accepted this cycle
//   issue_valid_o        head is valid
//   fall_through_o       head is taken straight from the decoder input
//   write_en_o           accepted entry must be written into storage
//   wr_ptr_o, rd_ptr_o   storage pointers
//   count_o, cf_count_o  occupancy and buffered control-flow entries
module id_queue_ctrl
   import id_issue_queue_pkg::*;
#(
   parameter int unsigned  Depth       = 2,
   parameter int unsigned  MaxCtrlFlow = Depth,
   parameter bit           FallThrough = 1'b0,
   localparam int unsigned CntW        = $clog2(Depth + 1),
   localparam int unsigned PtrW        = ptr_width(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            decode_valid_i,
   input  logic            is_ctrl_flow_i,
   input  logic            issue_instr_ack_i,
   input  logic            head_ctrl_flow_i,
   output logic            decode_ready_o,
   output logic            issue_valid_o,
   output logic            fall_through_o,
   output logic            write_en_o,
   output logic [PtrW-1:0] wr_ptr_o,
   output logic [PtrW-1:0] rd_ptr_o,
   output logic [CntW-1:0] count_o,
   output logic [CntW-1:0] cf_count_o
);

   logic [CntW-1:0] count_r, count_d_s;
   logic [CntW-1:0] cf_count_r, cf_count_d_s;
   logic [PtrW-1:0] wr_ptr_r, wr_ptr_d_s;
   logic [PtrW-1:0] rd_ptr_r, rd_ptr_d_s;

   logic empty_s, ft_s, cf_base_ok_s, cf_ok_s, issue_valid_s;
   logic pop_s, pop_st_s, space_s, ready_s, write_s, cf_in_s, cf_out_s;

   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 32'd1)) ? {PtrW{1'b0}} : p + PtrW'(1);
   endfunction

   // Handshake decisions. The cf limit is split into a pop-independent part
   // so the head valid (which needs it in fall-through) does not depend on
   // pop; when empty cf_count is 0, so the split is exact. rst_ni gates the
   // handshake outputs so they read 0 while reset is held.
   always_comb begin
      empty_s      = (count_r == {CntW{1'b0}});
      ft_s         = FallThrough && empty_s;
      cf_base_ok_s = !is_ctrl_flow_i || (cf_count_r < CntW'(MaxCtrlFlow));
      if (ft_s) begin
         issue_valid_s = rst_ni && decode_valid_i && cf_base_ok_s && !flush_i;
      end else begin
         issue_valid_s = rst_ni && !empty_s && !flush_i;
      end
      pop_s    = issue_instr_ack_i && issue_valid_s;
      pop_st_s = pop_s && !ft_s;
      cf_ok_s  = cf_base_ok_s || (pop_s && head_ctrl_flow_i);
      space_s  = (count_r < CntW'(Depth)) || pop_s;
      ready_s  = rst_ni && decode_valid_i && space_s && cf_ok_s && !flush_i;
      // An entry that falls through and is consumed at once never touches storage.
      write_s  = ready_s && !(ft_s && pop_s);
      cf_in_s  = write_s && is_ctrl_flow_i;
      cf_out_s = pop_st_s && head_ctrl_flow_i;
   end

   // Next-state for pointers and counters; flush overrides push and pop.
   always_comb begin
      count_d_s    = count_r;
      cf_count_d_s = cf_count_r;
      wr_ptr_d_s   = wr_ptr_r;
      rd_ptr_d_s   = rd_ptr_r;
      if (flush_i) begin
         count_d_s    = {CntW{1'b0}};
         cf_count_d_s = {CntW{1'b0}};
         wr_ptr_d_s   = {PtrW{1'b0}};
         rd_ptr_d_s   = {PtrW{1'b0}};
      end else begin
         case ({write_s, pop_st_s})
            2'b10:   count_d_s = count_r + CntW'(1);
            2'b01:   count_d_s = count_r - CntW'(1);
            default: count_d_s = count_r;
         endcase
         case ({cf_in_s, cf_out_s})
            2'b10:   cf_count_d_s = cf_count_r + CntW'(1);
            2'b01:   cf_count_d_s = cf_count_r - CntW'(1);
            default: cf_count_d_s = cf_count_r;
         endcase
         if (write_s) begin
            wr_ptr_d_s = wrap_inc(wr_ptr_r);
         end else begin
            wr_ptr_d_s = wr_ptr_r;
         end
         if (pop_st_s) begin
            rd_ptr_d_s = wrap_inc(rd_ptr_r);
         end else begin
            rd_ptr_d_s = rd_ptr_r;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_r    <= {CntW{1'b0}};
         cf_count_r <= {CntW{1'b0}};
         wr_ptr_r   <= {PtrW{1'b0}};
         rd_ptr_r   <= {PtrW{1'b0}};
      end else begin
         count_r    <= count_d_s;
         cf_count_r <= cf_count_d_s;
         wr_ptr_r   <= wr_ptr_d_s;
         rd_ptr_r   <= rd_ptr_d_s;
      end
   end

   assign decode_ready_o = ready_s;
   assign issue_valid_o  = issue_valid_s;
   assign fall_through_o = ft_s;
   assign write_en_o     = write_s;
   assign wr_ptr_o       = wr_ptr_r;
   assign rd_ptr_o       = rd_ptr_r;
   assign count_o        = count_r;
   assign cf_count_o     = cf_count_r;

endmodule

// File: rtl/id_issue_queue.sv
// ID/issue queue: circular FIFO of decoded entries between decoder and issue,
// with optional fall-through when empty and a cap on buffered control flow.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              discard all entries
//   decoded_entry_i      decoded instruction, is_ctrl_flow_i its cf flag
//   decode_valid_i/decode_ready_o   decoder handshake
//   issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o   head entry
//   issue_instr_ack_i    issue consumed the head
//   usage_o              registered occupancy
module id_issue_queue
   import ariane_pkg::*;
   import id_issue_queue_pkg::*;
#(
   parameter int unsigned Depth       = 2,
   parameter bit          FallThrough = 1'b0,
   parameter int unsigned MaxCtrlFlow = Depth
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  scoreboard_entry_t            decoded_entry_i,
   input  logic                         is_ctrl_flow_i,
   input  logic                         decode_valid_i,
   output logic                         decode_ready_o,
   output scoreboard_entry_t            issue_entry_o,
   output logic                         issue_entry_valid_o,
   output logic                         is_ctrl_flow_o,
   input  logic                         issue_instr_ack_i,
   output logic [$clog2(Depth+1)-1:0]   usage_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned PtrW = ptr_width(Depth);

   id_entry_t       mem_r [Depth];
   id_entry_t       head_s;
   logic            ft_s, write_en_s;
   logic [PtrW-1:0] wr_ptr_s, rd_ptr_s;
   logic [CntW-1:0] count_s, cf_count_s;

   id_queue_ctrl #(
      .Depth       (Depth),
      .MaxCtrlFlow (MaxCtrlFlow),
      .FallThrough (FallThrough)
   ) u_ctrl (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .flush_i           (flush_i),
      .decode_valid_i    (decode_valid_i),
      .is_ctrl_flow_i    (is_ctrl_flow_i),
      .issue_instr_ack_i (issue_instr_ack_i),
      .head_ctrl_flow_i  (head_s.is_ctrl_flow),
      .decode_ready_o    (decode_ready_o),
      .issue_valid_o     (issue_entry_valid_o),
      .fall_through_o    (ft_s),
      .write_en_o        (write_en_s),
      .wr_ptr_o          (wr_ptr_s),
      .rd_ptr_o          (rd_ptr_s),
      .count_o           (count_s),
      .cf_count_o        (cf_count_s)
   );

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (write_en_s) begin
         mem_r[wr_ptr_s] <= '{sbe: decoded_entry_i, is_ctrl_flow: is_ctrl_flow_i};
      end
   end

   // Head select: decoder input when falling through, else the slot at the
   // read pointer; zeros when nothing is buffered so stale storage never leaks.
   always_comb begin
      head_s = '{sbe: '0, is_ctrl_flow: 1'b0};
      if (!rst_ni) begin
         head_s = '{sbe: '0, is_ctrl_flow: 1'b0};
      end else if (ft_s) begin
         head_s = '{sbe: decoded_entry_i, is_ctrl_flow: is_ctrl_flow_i};
      end else if (count_s != {CntW{1'b0}}) begin
         head_s = mem_r[rd_ptr_s];
      end else begin
         head_s = '{sbe: '0, is_ctrl_flow: 1'b0};
      end
   end

   assign issue_entry_o  = head_s.sbe;
   assign is_ctrl_flow_o = head_s.is_ctrl_flow;
   assign usage_o        = count_s;

   id_issue_queue_sva #(
      .Depth       (Depth),
      .MaxCtrlFlow (MaxCtrlFlow),
      .FallThrough (FallThrough)
   ) u_sva (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .count_i           (count_s),
      .cf_count_i        (cf_count_s),
      .issue_instr_ack_i (issue_instr_ack_i),
      .decode_valid_i    (decode_valid_i),
      .decode_ready_i    (decode_ready_o),
      .decoded_entry_i   (decoded_entry_i)
   );

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: three configurations (Depth 2 with one cf slot,
// Depth 2 fall-through, Depth 3 random traffic against a queue model).
module tb_id_issue_queue;
   import ariane_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic f0, v0, c0, a0, r0, iv0, ic0; scoreboard_entry_t e0, ie0; logic [1:0] u0;
   logic f1, v1, c1, a1, r1, iv1, ic1; scoreboard_entry_t e1, ie1; logic [1:0] u1;
   logic f2, v2, c2, a2, r2, iv2, ic2; scoreboard_entry_t e2, ie2; logic [1:0] u2;

   int checks = 0;
   int errors = 0;

   id_issue_queue #(.Depth(2), .FallThrough(1'b0), .MaxCtrlFlow(1)) u_q0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(f0), .decoded_entry_i(e0),
      .is_ctrl_flow_i(c0), .decode_valid_i(v0), .decode_ready_o(r0),
      .issue_entry_o(ie0), .issue_entry_valid_o(iv0), .is_ctrl_flow_o(ic0),
      .issue_instr_ack_i(a0), .usage_o(u0));

   id_issue_queue #(.Depth(2), .FallThrough(1'b1), .MaxCtrlFlow(2)) u_q1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .decoded_entry_i(e1),
      .is_ctrl_flow_i(c1), .decode_valid_i(v1), .decode_ready_o(r1),
      .issue_entry_o(ie1), .issue_entry_valid_o(iv1), .is_ctrl_flow_o(ic1),
      .issue_instr_ack_i(a1), .usage_o(u1));

   id_issue_queue #(.Depth(3), .FallThrough(1'b0), .MaxCtrlFlow(3)) u_q2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(f2), .decoded_entry_i(e2),
      .is_ctrl_flow_i(c2), .decode_valid_i(v2), .decode_ready_o(r2),
      .issue_entry_o(ie2), .issue_entry_valid_o(iv2), .is_ctrl_flow_o(ic2),
      .issue_instr_ack_i(a2), .usage_o(u2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic scoreboard_entry_t mk(input int unsigned n);
      scoreboard_entry_t s;
      s.pc = 32'(32'h1000_0000 + n * 32'd4);
      s.op = 8'(n * 32'd3 + 32'd1);
      s.rd = 5'(n);
      return s;
   endfunction

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   scoreboard_entry_t mq[$];
   logic              mcf[$];
   scoreboard_entry_t hd;
   logic              exp_ready, pend;
   int                pushes, pops, n;

   initial begin
      rst_n = 1'b0;
      {f0, v0, c0, a0, f1, v1, c1, a1, f2, v2, c2, a2} = '0;
      e0 = '0; e1 = '0; e2 = '0;
      #2;
      chk("rst_ready", 64'(r0), 64'(1'b0));
      chk("rst_valid", 64'(iv0), 64'(1'b0));
      chk("rst_entry", 64'(ie0), 64'(0));
      chk("rst_cf", 64'(ic0), 64'(1'b0));
      chk("rst_usage", 64'(u0), 64'(0));
      cyc(); cyc();
      rst_n = 1'b1;

      // 1: fill Depth=2 without ack
      cyc(); v0 = 1'b1; e0 = mk(1); #1;
      chk("t1_readyA", 64'(r0), 64'(1'b1));
      chk("t1_validA", 64'(iv0), 64'(1'b0));
      cyc(); e0 = mk(2); #1;
      chk("t1_readyB", 64'(r0), 64'(1'b1));
      chk("t1_headA", 64'(ie0), 64'(mk(1)));
      chk("t1_validB", 64'(iv0), 64'(1'b1));
      chk("t1_usage1", 64'(u0), 64'(1));
      cyc(); e0 = mk(3); #1;
      chk("t1_readyC", 64'(r0), 64'(1'b0));
      chk("t1_usage2", 64'(u0), 64'(2));
      // 2: full queue, push with simultaneous pop
      cyc(); a0 = 1'b1; #1;
      chk("t2_readyC", 64'(r0), 64'(1'b1));
      chk("t2_headA", 64'(ie0), 64'(mk(1)));
      cyc(); v0 = 1'b0; #1;
      chk("t2_headB", 64'(ie0), 64'(mk(2)));
      chk("t2_usage2", 64'(u0), 64'(2));
      cyc(); #1;
      chk("t2_headC", 64'(ie0), 64'(mk(3)));
      chk("t2_usage1", 64'(u0), 64'(1));
      cyc(); a0 = 1'b0; #1;
      chk("t2_usage0", 64'(u0), 64'(0));
      chk("t2_empty", 64'(iv0), 64'(1'b0));

      // 3: control-flow limit of one
      cyc(); v0 = 1'b1; e0 = mk(4); c0 = 1'b1; #1;
      chk("t3_readyX", 64'(r0), 64'(1'b1));
      cyc(); e0 = mk(5); #1;
      chk("t3_blockY", 64'(r0), 64'(1'b0));
      chk("t3_headX", 64'(ie0), 64'(mk(4)));
      chk("t3_cfX", 64'(ic0), 64'(1'b1));
      cyc(); a0 = 1'b1; #1;
      chk("t3_readyY_ack", 64'(r0), 64'(1'b1));
      cyc(); v0 = 1'b0; #1;
      chk("t3_headY", 64'(ie0), 64'(mk(5)));
      chk("t3_cfY", 64'(ic0), 64'(1'b1));
      chk("t3_usage1", 64'(u0), 64'(1));
      cyc(); a0 = 1'b0; c0 = 1'b0; #1;
      chk("t3_usage0", 64'(u0), 64'(0));

      // 4: flush with two entries and a pending push
      cyc(); v0 = 1'b1; e0 = mk(6); #1;
      cyc(); e0 = mk(7); #1;
      cyc(); e0 = mk(8); f0 = 1'b1; #1;
      chk("t4_flush_valid", 64'(iv0), 64'(1'b0));
      chk("t4_flush_ready", 64'(r0), 64'(1'b0));
      chk("t4_usage_pre", 64'(u0), 64'(2));
      cyc(); f0 = 1'b0; #1;
      chk("t4_usage_post", 64'(u0), 64'(0));
      chk("t4_valid_post", 64'(iv0), 64'(1'b0));
      chk("t4_ready_post", 64'(r0), 64'(1'b1));
      cyc(); v0 = 1'b0; a0 = 1'b1; #1;
      chk("t4_headF", 64'(ie0), 64'(mk(8)));
      chk("t4_validF", 64'(iv0), 64'(1'b1));
      cyc(); a0 = 1'b0; #1;
      chk("t4_drain", 64'(u0), 64'(0));

      // 5: fall-through
      cyc(); v1 = 1'b1; e1 = mk(9); a1 = 1'b1; #1;
      chk("t5_ft_valid", 64'(iv1), 64'(1'b1));
      chk("t5_ft_head", 64'(ie1), 64'(mk(9)));
      chk("t5_ft_ready", 64'(r1), 64'(1'b1));
      chk("t5_ft_usage", 64'(u1), 64'(0));
      cyc(); v1 = 1'b0; a1 = 1'b0; #1;
      chk("t5_ft_usage_after", 64'(u1), 64'(0));
      chk("t5_ft_valid_after", 64'(iv1), 64'(1'b0));
      cyc(); v1 = 1'b1; e1 = mk(10); #1;
      chk("t5_st_head", 64'(ie1), 64'(mk(10)));
      chk("t5_st_ready", 64'(r1), 64'(1'b1));
      cyc(); v1 = 1'b0; a1 = 1'b1; #1;
      chk("t5_st_usage", 64'(u1), 64'(1));
      chk("t5_st_headq", 64'(ie1), 64'(mk(10)));
      chk("t5_st_valid", 64'(iv1), 64'(1'b1));
      cyc(); a1 = 1'b0; #1;
      chk("t5_st_drain", 64'(u1), 64'(0));

      // 6: Depth=3 random traffic against a queue model
      pushes = 0; pops = 0; n = 20; pend = 1'b0;
      for (int i = 0; i < 300 && (pops < 10 || pushes < 10); i++) begin
         cyc();
         if (!pend) begin
            v2 = ($urandom_range(0, 99) < 65);
            e2 = mk(n);
            c2 = 1'($urandom_range(0, 1));
            n++;
         end
         a2 = (mq.size() > 0) && ($urandom_range(0, 99) < 55);
         #1;
         exp_ready = v2 && ((mq.size() < 3) || a2);
         chk("t6_ready", 64'(r2), 64'(exp_ready));
         chk("t6_usage", 64'(u2), 64'(mq.size()));
         chk("t6_valid", 64'(iv2), 64'(mq.size() > 0));
         if (mq.size() > 0) begin
            hd = mq[0];
            chk("t6_head", 64'(ie2), 64'(hd));
            chk("t6_cf", 64'(ic2), 64'(mcf[0]));
         end
         pend = v2 && !exp_ready;
         if (a2) begin
            void'(mq.pop_front());
            void'(mcf.pop_front());
            pops++;
         end
         if (exp_ready) begin
            mq.push_back(e2);
            mcf.push_back(c2);
            pushes++;
         end
      end
      chk("t6_progress", 64'(pops >= 10 && pushes >= 10), 64'(1'b1));

      // asynchronous reset with entries buffered and a push offered
      cyc(); a2 = 1'b0; v2 = 1'b1;
      if (!pend) begin
         e2 = mk(99);
         c2 = 1'b1;
      end
      #1;
      cyc(); #1;
      cyc(); rst_n = 1'b0; #1;
      chk("t6_rst_ready", 64'(r2), 64'(1'b0));
      chk("t6_rst_valid", 64'(iv2), 64'(1'b0));
      chk("t6_rst_entry", 64'(ie2), 64'(0));
      chk("t6_rst_cf", 64'(ic2), 64'(1'b0));
      chk("t6_rst_usage", 64'(u2), 64'(0));
      cyc(); rst_n = 1'b1; v2 = 1'b0; #1;
      chk("t6_post_usage", 64'(u2), 64'(0));
      chk("t6_post_valid", 64'(iv2), 64'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
